rep_seq_checker: RTL

- Synthesizable run-time checker for repetition sequences. It sequences one evaluation attempt at a time of the property "rose(b) |-> b[->N] ##1 a" (goto mode) or "rose(b) |-> b[=N] ##1 a" (non-consecutive mode).
- Sits beside the a/b stimulus datapath and reports pass/fail pulses and counts. This lets the behaviour be checked in silicon or emulation where SVA is unavailable.
- Adds a timeout, because hardware cannot wait unboundedly.

---
 rtl/rep_seq_checker.sv | 113 +++++++++++
 1 files changed

// File: rtl/rep_seq_checker.sv
// rep_seq_checker: run-time checker for rose(b) |-> b[->N] ##1 a (mode 0) or b[=N] ##1 a (mode 1)
// with live timeout, registered pass/fail pulses and saturating statistics.
module rep_seq_checker #(
    parameter int CNT_W  = 4,
    parameter int TMO_W  = 8,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              mode,
    input  logic [CNT_W-1:0]  rep_n,
    input  logic [TMO_W-1:0]  timeout,
    input  logic              b,
    input  logic              a,
    output logic              busy,
    output logic              pass,
    output logic              fail,
    output logic [1:0]        fail_code,
    output logic [STAT_W-1:0] pass_cnt,
    output logic [STAT_W-1:0] fail_cnt
);
    typedef enum logic [2:0] {IDLE, COUNT, CHECK_A, WAIT_A, CFG_ERR} state_t;

    state_t             state, state_nx;
    logic               b_q, mode_q, trig, pass_nx, fail_nx;
    logic [CNT_W-1:0]   n_q, cnt, cnt_nx, cnt_inc;
    logic [TMO_W-1:0]   elapsed;
    logic [1:0]         code_nx;

    assign trig    = en & b & ~b_q & (state == IDLE);
    assign cnt_inc = cnt + 1'b1;
    assign busy    = state != IDLE;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        pass_nx  = 1'b0;
        fail_nx  = 1'b0;
        code_nx  = fail_code;
        if (state != IDLE && !en) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE: if (trig) begin
                    cnt_nx   = 1;
                    state_nx = (rep_n == '0) ? CFG_ERR :
                               (rep_n == 1)  ? (mode ? WAIT_A : CHECK_A) : COUNT;
                end
                COUNT: if (b) begin
                    cnt_nx   = cnt_inc;
                    state_nx = (cnt_inc == n_q) ? (mode_q ? WAIT_A : CHECK_A) : COUNT;
                end
                CHECK_A: begin
                    state_nx = IDLE;
                    pass_nx  = a;
                    fail_nx  = ~a;
                    code_nx  = a ? fail_code : 2'd1;
                end
                WAIT_A: begin
                    pass_nx  = a;
                    fail_nx  = ~a & b;
                    code_nx  = (~a & b) ? 2'd1 : fail_code;
                    state_nx = (a | b) ? IDLE : WAIT_A;
                end
                CFG_ERR: begin
                    state_nx = IDLE;
                    fail_nx  = 1'b1;
                    code_nx  = 2'd3;
                end
                default: state_nx = IDLE;
            endcase
            // timeout only fires when nothing else resolved the attempt this edge
            if (state != IDLE && !pass_nx && !fail_nx && timeout != '0 && elapsed == timeout) begin
                state_nx = IDLE;
                fail_nx  = 1'b1;
                code_nx  = 2'd2;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            b_q       <= 1'b0;
            mode_q    <= 1'b0;
            n_q       <= '0;
            cnt       <= '0;
            elapsed   <= '0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            fail_code <= '0;
            pass_cnt  <= '0;
            fail_cnt  <= '0;
        end else begin
            state     <= state_nx;
            b_q       <= b;
            cnt       <= cnt_nx;
            pass      <= pass_nx;
            fail      <= fail_nx;
            fail_code <= code_nx;
            if (trig) begin
                mode_q  <= mode;
                n_q     <= rep_n;
                elapsed <= '0;
            end else if (state != IDLE) begin
                elapsed <= elapsed + 1'b1;
            end
            if (pass_nx && !(&pass_cnt)) pass_cnt <= pass_cnt + 1'b1;
            if (fail_nx && !(&fail_cnt)) fail_cnt <= fail_cnt + 1'b1;
        end
    end
endmodule
